// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and lane helpers.
// Sizes follow the RISC-V funct3[1:0] convention so they can be wired straight from decode.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } mem_state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] be_base(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between the core and a doubleword-wide data memory.
// Purely combinational: store shift + byte enables, load extract + sign/zero extend.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      st_off,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_be,
  input  logic [2:0]      ld_off,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shift;

  assign st_wdata = st_data << {st_off, 3'b000};
  assign st_be    = be_base(st_size) << st_off;
  assign ld_shift = ld_rdata >> {ld_off, 3'b000};

  // Truncate to the access size, then replicate either zero or the top bit.
  always_comb begin
    ld_data = ld_shift;
    case (ld_size)
      SZ_B: ld_data = {{(XLEN-8){~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H: ld_data = {{(XLEN-16){~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      SZ_W: ld_data = {{(XLEN-32){~ld_unsigned & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 64-bit pipeline: drives a req/gnt/rvalid data port,
// stalls upstream while an access is in flight and registers the MEM->WB bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic            MemToRegM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [1:0]      MemSizeM,
  input  logic            MemUnsignedM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            StallM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic            MemToRegW,
  output logic            MisalignW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW
);

  mem_state_e state;

  logic            is_mem;
  logic            aligned;
  logic            start;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      st_be;
  logic [XLEN-1:0] ld_data;

  logic [2:0]      ld_off;
  logic [1:0]      ld_size;
  logic            ld_unsigned;
  logic            hold_load;
  logic            hold_regwrite;
  logic            hold_memtoreg;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_alu;
  logic [XLEN-1:0] hold_rdata;

  assign is_mem  = ValidM & (MemReadM | MemWriteM);
  assign aligned = (ALU_ResultM[2:0] & size_mask(MemSizeM)) == 3'b000;
  assign start   = is_mem & aligned;

  // Store lanes come from the live inputs; load lanes from the offset latched at start.
  mem_align #(.XLEN(XLEN)) u_align (
    .st_off      (ALU_ResultM[2:0]),
    .st_size     (MemSizeM),
    .st_data     (WriteDataM),
    .st_wdata    (st_wdata),
    .st_be       (st_be),
    .ld_off      (ld_off),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  // DONE releases the stall so the next instruction enters MEM right after it.
  always_comb begin
    StallM = 1'b0;
    if (reset) begin
      case (state)
        MS_IDLE:         StallM = start;
        MS_REQ, MS_WAIT: StallM = 1'b1;
        default:         StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= MS_IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      ValidW        <= 1'b0;
      RegWriteW     <= 1'b0;
      MemToRegW     <= 1'b0;
      MisalignW     <= 1'b0;
      RD_W          <= '0;
      ALU_ResultW   <= '0;
      ReadDataW     <= '0;
      ld_off        <= '0;
      ld_size       <= '0;
      ld_unsigned   <= 1'b0;
      hold_load     <= 1'b0;
      hold_regwrite <= 1'b0;
      hold_memtoreg <= 1'b0;
      hold_rd       <= '0;
      hold_alu      <= '0;
      hold_rdata    <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            ValidW        <= 1'b0;
            RegWriteW     <= 1'b0;
            MemToRegW     <= 1'b0;
            MisalignW     <= 1'b0;
            dmem_req      <= 1'b1;
            dmem_we       <= MemWriteM;
            dmem_addr     <= {ALU_ResultM[XLEN-1:3], 3'b000};
            dmem_wdata    <= st_wdata;
            dmem_be       <= st_be;
            ld_off        <= ALU_ResultM[2:0];
            ld_size       <= MemSizeM;
            ld_unsigned   <= MemUnsignedM;
            hold_load     <= MemReadM & ~MemWriteM;
            hold_regwrite <= RegWriteM;
            hold_memtoreg <= MemToRegM;
            hold_rd       <= RD_M;
            hold_alu      <= ALU_ResultM;
            state         <= MS_REQ;
          end else begin
            // Pass-through; a memory op reaching here is misaligned and must not write back.
            ValidW      <= ValidM;
            RegWriteW   <= RegWriteM & ~is_mem;
            MemToRegW   <= MemToRegM;
            MisalignW   <= is_mem;
            RD_W        <= RD_M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= '0;
          end
        end
        MS_REQ: begin
          ValidW    <= 1'b0;
          RegWriteW <= 1'b0;
          MemToRegW <= 1'b0;
          MisalignW <= 1'b0;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? MS_DONE : MS_WAIT;
          end
        end
        MS_WAIT: begin
          ValidW    <= 1'b0;
          RegWriteW <= 1'b0;
          MemToRegW <= 1'b0;
          MisalignW <= 1'b0;
          if (dmem_rvalid) begin
            hold_rdata <= ld_data;
            state      <= MS_DONE;
          end
        end
        MS_DONE: begin
          ValidW      <= 1'b1;
          RegWriteW   <= hold_regwrite;
          MemToRegW   <= hold_memtoreg;
          MisalignW   <= 1'b0;
          RD_W        <= hold_rd;
          ALU_ResultW <= hold_alu;
          ReadDataW   <= hold_load ? hold_rdata : '0;
          state       <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule
